// File: rtl/fir_coeff_controller.sv
// FIR coefficient controller: host writes taps into a shadow bank, a commit
// request waits for the next filter sample boundary, then the shadow bank is
// swapped into the active bank and the filter delay line is flushed.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_LOAD  | accepting host writes into the shadow bank
// ST_PEND  | commit requested, waiting for a sample_strobe to swap banks
// ST_FLUSH | new bank active, holding filter_flush for FLUSH_CYCLES cycles
module fir_coeff_controller #(
  parameter int NUM_TAPS     = 8,
  parameter int COEFF_WIDTH  = 16,
  parameter int FLUSH_CYCLES = 8,
  localparam int ADDR_W      = $clog2(NUM_TAPS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [ADDR_W-1:0]               cfg_addr,
  input  logic [COEFF_WIDTH-1:0]          cfg_data,
  input  logic                            cfg_last,
  input  logic                            sample_strobe,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_bus,
  output logic                            filter_flush,
  output logic                            bank_sel,
  output logic                            busy,
  output logic                            cfg_error,
  output logic [7:0]                      swap_count
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef logic [COEFF_WIDTH-1:0] coeff_t;

  state_t           state_q, state_d;
  coeff_t           shadow_q [NUM_TAPS];
  coeff_t           shadow_d [NUM_TAPS];
  coeff_t           bank0_q  [NUM_TAPS];
  coeff_t           bank0_d  [NUM_TAPS];
  coeff_t           bank1_q  [NUM_TAPS];
  coeff_t           bank1_d  [NUM_TAPS];
  logic             bank_sel_q, bank_sel_d;
  logic             filter_flush_q, filter_flush_d;
  logic             busy_q, busy_d;
  logic             cfg_error_q, cfg_error_d;
  logic [7:0]       swap_count_q, swap_count_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             addr_ok;

  assign addr_ok = (int'(cfg_addr) < NUM_TAPS);

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    bank0_d        = bank0_q;
    bank1_d        = bank1_q;
    bank_sel_d     = bank_sel_q;
    filter_flush_d = filter_flush_q;
    cfg_error_d    = cfg_error_q;
    swap_count_d   = swap_count_q;
    flush_cnt_d    = flush_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        if (cfg_valid) begin
          // Out-of-range writes are consumed so the host never stalls.
          if (addr_ok) begin
            shadow_d[cfg_addr] = cfg_data;
          end else begin
            cfg_error_d = 1'b1;
          end
          if (cfg_last) begin
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (sample_strobe) begin
          // The bank that goes active receives the shadow; the old active
          // set stays untouched in the other bank.
          if (bank_sel_q) begin
            bank0_d = shadow_q;
          end else begin
            bank1_d = shadow_q;
          end
          bank_sel_d     = ~bank_sel_q;
          swap_count_d   = swap_count_q + 8'd1;
          flush_cnt_d    = FLUSH_CNT_INIT;
          filter_flush_d = 1'b1;
          state_d        = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          filter_flush_d = 1'b0;
          state_d        = ST_LOAD;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    busy_d = (state_d != ST_LOAD);
  end

  // State and output registers with synchronous reset to passthrough taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_LOAD;
      bank_sel_q     <= 1'b0;
      filter_flush_q <= 1'b0;
      busy_q         <= 1'b0;
      cfg_error_q    <= 1'b0;
      swap_count_q   <= '0;
      flush_cnt_q    <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= (k == 0) ? coeff_t'(1) : '0;
        bank0_q[k]  <= (k == 0) ? coeff_t'(1) : '0;
        bank1_q[k]  <= (k == 0) ? coeff_t'(1) : '0;
      end
    end else begin
      state_q        <= state_d;
      bank_sel_q     <= bank_sel_d;
      filter_flush_q <= filter_flush_d;
      busy_q         <= busy_d;
      cfg_error_q    <= cfg_error_d;
      swap_count_q   <= swap_count_d;
      flush_cnt_q    <= flush_cnt_d;
      shadow_q       <= shadow_d;
      bank0_q        <= bank0_d;
      bank1_q        <= bank1_d;
    end
  end

  // Active bank mux onto the flat coefficient bus.
  always_comb begin
    coeff_bus = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      coeff_bus[k*COEFF_WIDTH +: COEFF_WIDTH] = bank_sel_q ? bank1_q[k] : bank0_q[k];
    end
  end

  assign cfg_ready    = (state_q == ST_LOAD);
  assign filter_flush = filter_flush_q;
  assign bank_sel     = bank_sel_q;
  assign busy         = busy_q;
  assign cfg_error    = cfg_error_q;
  assign swap_count   = swap_count_q;

endmodule

// File: tb/tb_fir_coeff_controller.sv
// Bench for fir_coeff_controller: two instances (8 taps / flush 8 and
// 6 taps / flush 1) share one host stimulus and are compared every cycle
// against a transaction-level model of the commit/swap/flush behaviour.
module tb_fir_coeff_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic [2:0]   cfg_addr;
  logic [15:0]  cfg_data;
  logic         cfg_last;
  logic         sample_strobe;

  logic         ready_a, flush_a, bsel_a, busy_a, err_a;
  logic [127:0] bus_a;
  logic [7:0]   swc_a;
  logic         ready_b, flush_b, bsel_b, busy_b, err_b;
  logic [95:0]  bus_b;
  logic [7:0]   swc_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fir_coeff_controller #(.NUM_TAPS(8), .COEFF_WIDTH(16), .FLUSH_CYCLES(8)) u_dut_a (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .sample_strobe(sample_strobe), .coeff_bus(bus_a), .filter_flush(flush_a),
    .bank_sel(bsel_a), .busy(busy_a), .cfg_error(err_a), .swap_count(swc_a)
  );

  fir_coeff_controller #(.NUM_TAPS(6), .COEFF_WIDTH(16), .FLUSH_CYCLES(1)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .sample_strobe(sample_strobe), .coeff_bus(bus_b), .filter_flush(flush_b),
    .bank_sel(bsel_b), .busy(busy_b), .cfg_error(err_b), .swap_count(swc_b)
  );

  // Reference model: per instance, the shadow and active tap sets, whether a
  // commit is waiting, and how many flush cycles remain.
  int          m_ntaps [2] = '{8, 6};
  int          m_nflush[2] = '{8, 1};
  logic [15:0] m_shadow[2][8];
  logic [15:0] m_active[2][8];
  bit          m_pending[2];
  int          m_flush_left[2];
  bit          m_bank[2];
  bit          m_err[2];
  int          m_swaps[2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] model_bus(input int m);
    logic [127:0] r = '0;
    for (int k = 0; k < m_ntaps[m]; k++) r[k*16 +: 16] = m_active[m][k];
    return r;
  endfunction

  task automatic model_reset(input int m);
    for (int k = 0; k < 8; k++) begin
      m_shadow[m][k] = (k == 0) ? 16'd1 : 16'd0;
      m_active[m][k] = (k == 0) ? 16'd1 : 16'd0;
    end
    m_pending[m] = 0; m_flush_left[m] = 0; m_bank[m] = 0; m_err[m] = 0; m_swaps[m] = 0;
  endtask

  task automatic model_edge(input int m);
    if (reset) begin
      model_reset(m);
    end else if (m_flush_left[m] > 0) begin
      m_flush_left[m]--;
    end else if (m_pending[m]) begin
      if (sample_strobe) begin
        m_pending[m] = 0;
        m_bank[m] = ~m_bank[m];
        for (int k = 0; k < 8; k++) m_active[m][k] = m_shadow[m][k];
        m_swaps[m] = (m_swaps[m] + 1) % 256;
        m_flush_left[m] = m_nflush[m];
      end
    end else if (cfg_valid) begin
      if (int'(cfg_addr) < m_ntaps[m]) m_shadow[m][cfg_addr] = cfg_data;
      else m_err[m] = 1;
      if (cfg_last) m_pending[m] = 1;
    end
  endtask

  task automatic compare_all();
    bit bz_a, bz_b;
    bz_a = m_pending[0] || (m_flush_left[0] > 0);
    bz_b = m_pending[1] || (m_flush_left[1] > 0);
    chk("a_coeff", bus_a, model_bus(0));
    chk("a_ready", ready_a, !bz_a);
    chk("a_busy",  busy_a,  bz_a);
    chk("a_flush", flush_a, m_flush_left[0] > 0);
    chk("a_bank",  bsel_a,  m_bank[0]);
    chk("a_err",   err_a,   m_err[0]);
    chk("a_swaps", swc_a,   m_swaps[0]);
    chk("b_coeff", {32'd0, bus_b}, model_bus(1));
    chk("b_ready", ready_b, !bz_b);
    chk("b_busy",  busy_b,  bz_b);
    chk("b_flush", flush_b, m_flush_left[1] > 0);
    chk("b_bank",  bsel_b,  m_bank[1]);
    chk("b_err",   err_b,   m_err[1]);
    chk("b_swaps", swc_b,   m_swaps[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    cfg_valid = 0; cfg_last = 0; sample_strobe = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d, input logic l, input logic s);
    cfg_valid = 1; cfg_addr = a; cfg_data = d; cfg_last = l; sample_strobe = s;
    cycle();
    cfg_valid = 0; cfg_last = 0; sample_strobe = 0;
  endtask

  task automatic strobe();
    sample_strobe = 1;
    cycle();
    sample_strobe = 0;
  endtask

  initial begin
    int flush_hi;
    int waited;
    bit pre_ready;
    reset = 1; cfg_valid = 0; cfg_addr = '0; cfg_data = '0; cfg_last = 0; sample_strobe = 0;
    model_reset(0);
    model_reset(1);

    // Reset state
    cycle(); cycle();
    chk("rst_bus", bus_a, 128'd1);
    chk("rst_ready", ready_a, 1'b1);
    reset = 0;
    idle(2);

    // Full load 10..17, commit, strobe three cycles later
    for (int i = 0; i < 8; i++) write(3'(i), 16'(10 + i), i == 7, 1'b0);
    chk("t2_ready_after_last", ready_a, 1'b0);
    idle(2);
    strobe();
    chk("t2_tap0", bus_a[15:0], 16'd10);
    chk("t2_tap7", bus_a[127:112], 16'd17);
    chk("t2_bank", bsel_a, 1'b1);
    flush_hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (flush_a) flush_hi++;
      cycle();
    end
    chk("t2_flush_len", flush_hi, 8);
    chk("t2_swaps", swc_a, 8'd1);

    // Partial update of tap 2 only
    write(3'd2, -16'sd5, 1'b1, 1'b0);
    idle(1);
    strobe();
    chk("t3_tap2", bus_a[47:32], 16'hfffb);
    chk("t3_tap3", bus_a[63:48], 16'd13);
    chk("t3_bank", bsel_a, 1'b0);
    idle(10);

    // Strobe coinciding with the commit write is ignored
    write(3'd1, 16'd7, 1'b1, 1'b1);
    idle(3);
    chk("t4_no_swap", swc_a, 8'd2);
    // Host holds a write through PEND/FLUSH; it lands once back in LOAD
    cfg_valid = 1; cfg_addr = 3'd0; cfg_data = 16'd99; cfg_last = 0;
    waited = 0;
    do begin
      pre_ready = ready_a;
      sample_strobe = (waited == 2);
      cycle();
      waited++;
    end while (!pre_ready && waited < 40);
    cfg_valid = 0; sample_strobe = 0;
    if (!pre_ready) chk("t4_wait_timeout", waited, 0);
    write(3'd4, 16'd44, 1'b1, 1'b0);
    strobe();
    chk("t4_tap0", bus_a[15:0], 16'd99);
    idle(10);

    // Out-of-range address on the 6-tap instance
    write(3'd7, 16'd55, 1'b1, 1'b0);
    chk("t5_err6", err_b, 1'b1);
    strobe();
    idle(10);

    // Reset during flush
    write(3'd3, 16'd33, 1'b1, 1'b0);
    strobe();
    idle(2);
    reset = 1;
    cycle();
    reset = 0;
    chk("t6_bus", bus_a, 128'd1);
    chk("t6_flush", flush_a, 1'b0);
    idle(2);

    // Randomized traffic including swap_count wrap
    for (int i = 0; i < 4000; i++) begin
      cfg_valid     = ($urandom_range(0, 3) != 0);
      cfg_addr      = 3'($urandom_range(0, 7));
      cfg_data      = 16'($urandom);
      cfg_last      = ($urandom_range(0, 3) == 0);
      sample_strobe = ($urandom_range(0, 2) == 0);
      reset         = (i == 100);
      cycle();
    end
    reset = 0;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
